// File: rtl/reg_bank_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter: bus widths and FSM state encoding.
package reg_bank_arbiter_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_IIC_WR    = 3'd1,
        ST_UART_RD   = 3'd2,
        ST_UART_WR   = 3'd3,
        ST_UART_DONE = 3'd4,
        ST_REFR      = 3'd5,
        ST_REFR_DONE = 3'd6
    } state_e;

endpackage

// File: rtl/reg_bank_arbiter.sv
// Arbitrates one external single-port RAM between I2C writes, UART commands and a
// background refresh that keeps iic_rdata tracking RAM[iic_addr].
//
// state      | meaning
// IDLE       | pick next access: pending I2C write > UART (if fair) > refresh
// IIC_WR     | write pending I2C entry to RAM
// UART_RD    | RAM read at uart_addr
// UART_WR    | RAM write of uart_wdata at uart_addr
// UART_DONE  | ack UART, capture read data, block UART until next refresh
// REFR       | RAM read at iic_addr
// REFR_DONE  | capture refresh data into iic_rdata
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] iic_addr,
    input  logic [DATA_W-1:0] iic_wdata,
    input  logic              iic_wr_en,
    output logic [DATA_W-1:0] iic_rdata,
    input  logic              uart_req,
    input  logic              uart_we,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_wdata,
    output logic              uart_ack,
    output logic [DATA_W-1:0] uart_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wr_overflow
);

    state_e              state_q, state_d;
    logic                pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic                fair_q, fair_d;
    logic                ovf_q, ovf_d;
    logic                uart_rd_q, uart_rd_d;
    logic [DATA_W-1:0]   iic_rdata_q, iic_rdata_d;
    logic [DATA_W-1:0]   uart_rdata_q, uart_rdata_d;
    logic [ADDR_W-1:0]   refr_addr_q, refr_addr_d;

    always_comb begin
        state_d      = state_q;
        pend_vld_d   = pend_vld_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        fair_d       = fair_q;
        ovf_d        = ovf_q;
        uart_rd_d    = uart_rd_q;
        iic_rdata_d  = iic_rdata_q;
        uart_rdata_d = uart_rdata_q;
        refr_addr_d  = refr_addr_q;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = refr_addr_q;
        mem_wdata    = '0;
        uart_ack     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // An arriving strobe counts as pending so it wins over a same-cycle UART request.
                if (pend_vld_q || iic_wr_en) begin
                    state_d = ST_IIC_WR;
                end else if (uart_req && !fair_q) begin
                    state_d   = uart_we ? ST_UART_WR : ST_UART_RD;
                    uart_rd_d = !uart_we;
                end else begin
                    state_d = ST_REFR;
                end
            end
            ST_IIC_WR: begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = pend_addr_q;
                mem_wdata  = pend_data_q;
                pend_vld_d = 1'b0;
                state_d    = ST_IDLE;
            end
            ST_UART_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = uart_addr;
                mem_wdata = uart_wdata;
                state_d   = ST_UART_DONE;
            end
            ST_UART_RD: begin
                mem_en   = 1'b1;
                mem_addr = uart_addr;
                state_d  = ST_UART_DONE;
            end
            ST_UART_DONE: begin
                uart_ack = 1'b1;
                if (uart_rd_q) begin
                    uart_rdata_d = mem_rdata;
                end
                fair_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_REFR: begin
                mem_en      = 1'b1;
                mem_addr    = iic_addr;
                refr_addr_d = iic_addr;
                fair_d      = 1'b0;
                state_d     = ST_REFR_DONE;
            end
            ST_REFR_DONE: begin
                iic_rdata_d = mem_rdata;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobe capture comes last so a reload in IIC_WR overrides the clear above.
        if (iic_wr_en) begin
            if (pend_vld_q && (state_q != ST_IIC_WR)) begin
                ovf_d = 1'b1;
            end
            pend_vld_d  = 1'b1;
            pend_addr_d = iic_addr;
            pend_data_d = iic_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pend_vld_q   <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            fair_q       <= 1'b0;
            ovf_q        <= 1'b0;
            uart_rd_q    <= 1'b0;
            iic_rdata_q  <= '0;
            uart_rdata_q <= '0;
            refr_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pend_vld_q   <= pend_vld_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            fair_q       <= fair_d;
            ovf_q        <= ovf_d;
            uart_rd_q    <= uart_rd_d;
            iic_rdata_q  <= iic_rdata_d;
            uart_rdata_q <= uart_rdata_d;
            refr_addr_q  <= refr_addr_d;
        end
    end

    // Read data is forwarded during the ack cycle so it is valid together with uart_ack.
    assign uart_rdata  = (state_q == ST_UART_DONE && uart_rd_q) ? mem_rdata : uart_rdata_q;
    assign iic_rdata   = iic_rdata_q;
    assign wr_overflow = ovf_q;

endmodule
